// File: rtl/turbo_pkg.sv
// Shared types and constants for the turbo decoder iteration scheduler.
// Holds the FSM state enum, the K = N/3 derivation and default QPP coefficients.
package turbo_pkg;

    localparam int ADDR_W = 8;
    localparam int DEF_F1 = 3;
    localparam int DEF_F2 = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALF1,
        S_WAIT1,
        S_HALF2,
        S_WAIT2,
        S_CHECK,
        S_OUTPUT
    } state_e;

    function automatic int k_of(input int n);
        return n / 3;
    endfunction

endpackage

// File: rtl/qpp_addr_gen.sv
// Incremental QPP interleaver address generator: pi(k) = (F1*k + F2*k^2) mod K.
// Ports: clk, rst, init (restart at k=0), step (advance k) -> pi, done (k == K-1).
module qpp_addr_gen
    import turbo_pkg::*;
#(
    parameter int K  = 8,
    parameter int F1 = DEF_F1,
    parameter int F2 = DEF_F2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init,
    input  logic              step,
    output logic [ADDR_W-1:0] pi,
    output logic              done
);

    localparam logic [8:0] K9 = 9'(K);
    localparam logic [8:0] G0 = 9'((F1 + F2) % K);
    localparam logic [8:0] D2 = 9'((2 * F2) % K);

    logic [8:0] pi_q, pi_d;
    logic [8:0] g_q, g_d;
    logic [7:0] k_q, k_d;
    logic [8:0] pi_sum, g_sum;

    // Operands stay below K, so one conditional subtract is a full mod.
    always_comb begin
        pi_sum = pi_q + g_q;
        if (pi_sum >= K9) pi_sum = pi_sum - K9;
        g_sum = g_q + D2;
        if (g_sum >= K9) g_sum = g_sum - K9;
        pi_d = pi_q;
        g_d  = g_q;
        k_d  = k_q;
        if (init) begin
            pi_d = '0;
            g_d  = G0;
            k_d  = '0;
        end else if (step) begin
            pi_d = pi_sum;
            g_d  = g_sum;
            k_d  = k_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pi_q <= '0;
            g_q  <= G0;
            k_q  <= '0;
        end else begin
            pi_q <= pi_d;
            g_q  <= g_d;
            k_q  <= k_d;
        end
    end

    assign pi   = pi_q[ADDR_W-1:0];
    assign done = (k_q == 8'(K - 1));

endmodule

// File: rtl/turbo_iter_ctrl.sv
// Turbo decoder iteration scheduler: accepts a block, alternates SISO half-iterations,
// stops on CRC pass or MAX_ITER, then streams hard-decision addresses out.
// Ports: blk_valid/blk_ready/ram_bank (deframer), siso_* (decoder), crc_ok,
// out_valid/out_ready/out_addr/out_last (consumer), iter_cnt/early_stop/busy (status).
module turbo_iter_ctrl
    import turbo_pkg::*;
#(
    parameter int N        = 24,
    parameter int MAX_ITER = 4,
    parameter int F1       = DEF_F1,
    parameter int F2       = DEF_F2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              blk_valid,
    output logic              blk_ready,
    output logic              ram_bank,
    output logic              siso_en,
    output logic [ADDR_W-1:0] siso_addr,
    output logic              siso_half,
    output logic              siso_first,
    output logic              siso_last,
    input  logic              siso_done,
    input  logic              crc_ok,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic [3:0]        iter_cnt,
    output logic              early_stop,
    output logic              busy
);

    localparam int K = k_of(N);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic [3:0]        iter_q, iter_d;
    logic              early_q, early_d;
    logic              bank_q, bank_d;
    logic              k_last;
    logic              qpp_init, qpp_step, qpp_done;
    logic [ADDR_W-1:0] qpp_pi;

    assign k_last   = (k_q == 8'(K - 1));
    // Restart pi on the WAIT1 exit edge so HALF2 opens at pi(0).
    assign qpp_init = (state_q == S_WAIT1) && siso_done;
    assign qpp_step = (state_q == S_HALF2);

    qpp_addr_gen #(
        .K  (K),
        .F1 (F1),
        .F2 (F2)
    ) u_qpp (
        .clk  (clk),
        .rst  (rst),
        .init (qpp_init),
        .step (qpp_step),
        .pi   (qpp_pi),
        .done (qpp_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            iter_q  <= '0;
            early_q <= 1'b0;
            bank_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            iter_q  <= iter_d;
            early_q <= early_d;
            bank_q  <= bank_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        iter_d  = iter_q;
        early_d = early_q;
        bank_d  = bank_q;
        unique case (state_q)
            S_IDLE: begin
                if (blk_valid) begin
                    state_d = S_HALF1;
                    bank_d  = ~bank_q;
                    iter_d  = 4'd1;
                    early_d = 1'b0;
                    k_d     = '0;
                end
            end
            S_HALF1: begin
                if (k_last) begin
                    state_d = S_WAIT1;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 8'd1;
                end
            end
            S_WAIT1: begin
                if (siso_done) state_d = S_HALF2;
            end
            S_HALF2: begin
                if (qpp_done) begin
                    state_d = S_WAIT2;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 8'd1;
                end
            end
            S_WAIT2: begin
                if (siso_done) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (crc_ok) begin
                    early_d = 1'b1;
                    state_d = S_OUTPUT;
                end else if (iter_q == 4'(MAX_ITER)) begin
                    state_d = S_OUTPUT;
                end else begin
                    iter_d  = iter_q + 4'd1;
                    state_d = S_HALF1;
                end
            end
            S_OUTPUT: begin
                if (out_ready) begin
                    if (k_last) begin
                        state_d = S_IDLE;
                        k_d     = '0;
                        iter_d  = '0;
                    end else begin
                        k_d = k_q + 8'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        blk_ready  = 1'b0;
        siso_en    = 1'b0;
        siso_addr  = '0;
        siso_half  = 1'b0;
        siso_first = 1'b0;
        siso_last  = 1'b0;
        out_valid  = 1'b0;
        out_addr   = '0;
        out_last   = 1'b0;
        unique case (state_q)
            S_IDLE: blk_ready = ~rst;
            S_HALF1: begin
                siso_en    = 1'b1;
                siso_addr  = k_q;
                siso_first = (k_q == '0);
                siso_last  = k_last;
            end
            S_HALF2: begin
                siso_en    = 1'b1;
                siso_half  = 1'b1;
                siso_addr  = qpp_pi;
                siso_first = (k_q == '0);
                siso_last  = qpp_done;
            end
            S_OUTPUT: begin
                out_valid = 1'b1;
                out_addr  = k_q;
                out_last  = k_last;
            end
            default: ;
        endcase
    end

    assign ram_bank   = bank_q;
    assign iter_cnt   = iter_q;
    assign early_stop = early_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: doc/turbo_iter_ctrl.md
# turbo_iter_ctrl

Iteration scheduler for the turbo decoder back end. It accepts one deframed block (K = N/3 triplets) from the serial deframer, time-shares a single SISO decoder between the natural-order and QPP-interleaved half-iterations, and stops early on CRC pass or at MAX_ITER. It then streams hard-decision read addresses to the downstream consumer under a valid/ready handshake. It owns the ping-pong bank select of the deframer RAM.

## Interface
Parameters:
- N, 24, encoded bits per block; must be a multiple of 3; K = N/3 is a derived localparam, 1 ≤ K ≤ 255
- MAX_ITER, 4, maximum full iterations, 1..15
- F1, 3, QPP coefficient f1 (odd)
- F2, 2, QPP coefficient f2 (even)

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous active-high reset
- blk_valid  in  1  deframer has a complete block in the current bank
- blk_ready  out  1  high only in IDLE; accept on blk_valid&&blk_ready
- ram_bank  out  1  bank the deframer writes next; toggles on accept
- siso_en  out  1  SISO input strobe, one symbol per cycle
- siso_addr  out  8  symbol index fed to SISO
- siso_half  out  1  0 = decoder-1 natural order, 1 = decoder-2 interleaved
- siso_first / siso_last  out  1  mark first / last strobe of a half-iteration
- siso_done  in  1  SISO pipeline flushed pulse; sampled only in WAIT1/WAIT2
- crc_ok  in  1  CRC result of current hard decisions; sampled only in CHECK
- out_valid  out  1  hard-decision address valid
- out_ready  in  1  consumer ready
- out_addr  out  8  natural-order index 0..K-1
- out_last  out  1  with out_valid on index K-1
- iter_cnt  out  4  current iteration, 1-based; 0 in IDLE
- early_stop  out  1  latched when CRC terminated the block; cleared on next accept
- busy  out  1  high in every state except IDLE

## Operation
- FSM: IDLE → HALF1 → WAIT1 → HALF2 → WAIT2 → CHECK → (HALF1 | OUTPUT) → IDLE.
- IDLE: blk_ready=1. On accept: toggle ram_bank, iter_cnt←1, early_stop←0, go to HALF1.
- HALF1: siso_en=1, siso_half=0, siso_addr = k for k=0..K-1, one per cycle. After k=K-1, go to WAIT1.
- WAIT1: hold until siso_done=1, then go to HALF2. Outputs are idle during the wait.
- HALF2: siso_half=1, siso_addr = π(k) = (F1·k + F2·k²) mod K for k=0..K-1. After k=K-1, go to WAIT2.
- π is generated incrementally, with no multiplier:
  - Start: π(0)=0, g(0)=(F1+F2) mod K.
  - Step: π(k+1) = (π(k)+g(k)) mod K, g(k+1) = (g(k)+2·F2) mod K.
  - Each mod is a single conditional subtract; operands are held < K in 9-bit arithmetic.
- WAIT2: hold until siso_done, then go to CHECK.
- CHECK: one cycle.
  - crc_ok=1: early_stop←1, go to OUTPUT.
  - else iter_cnt==MAX_ITER: go to OUTPUT.
  - else: iter_cnt+1, go to HALF1.
- OUTPUT: out_valid=1, out_addr counts 0..K-1 and advances only on out_valid&&out_ready. out_last marks K-1. The handshake on K-1 returns the FSM to IDLE.
- blk_valid outside IDLE is ignored. The deframer holds it because the accept never happens.
- siso_done in any state other than WAIT1/WAIT2 is ignored.

## Timing
- Reset values: blk_ready=0 during rst, 1 from the first cycle after; ram_bank=0; all other outputs 0; FSM=IDLE.
- Reset mid-block: FSM returns to IDLE next edge and the block is dropped. ram_bank returns to 0.
- Accept edge to first siso_en: 1 cycle.
- Half-iteration: exactly K consecutive strobe cycles with no bubbles.
- WAIT exit: the cycle after siso_done is seen. siso_done on the first WAIT cycle is legal.
- CHECK to next HALF1 strobe: 1 cycle. CHECK to first out_valid: 1 cycle.
- Minimum block time: 1 + I·(2K + 2·Wmin + 1) + K cycles, where I = iterations used and Wmin = 1.
- out_addr/out_valid are held stable while out_ready=0.
- K=1: siso_first and siso_last are asserted in the same cycle; out_last is asserted with the only beat.

## Structure
- Shared package `turbo_pkg`:
  - FSM state enum.
  - K = N/3 derivation.
  - Default QPP coefficients.
  - Address width constant (8).
- Sub-module `qpp_addr_gen`:
  - Inputs: clk, rst, init, step.
  - Outputs: π, and a done flag at k=K-1.
  - Instantiated once and restarted at each HALF2 entry.

## Test plan
- Basic block, N=24, K=8, crc_ok=1 in CHECK:
  - HALF1 addresses 0..7, then HALF2 addresses 0,5,6,3,4,1,2,7.
  - early_stop=1, iter_cnt=1, then 8 out beats 0..7 with out_last on 7.
- crc_ok held 0, MAX_ITER=4: exactly 4 HALF1/HALF2 pairs, iter_cnt 1→4, early_stop=0, then the output stream.
- out_ready toggled 1-0-1 each cycle: 8 beats in 15 cycles, and out_addr stable on every stall.
- blk_valid held high throughout: second accept only in IDLE, ram_bank toggles 0→1→0, blk_ready=0 while busy.
- siso_done pulsed during HALF1 and again in WAIT1 after 5 cycles: the first pulse is ignored and HALF2 starts the cycle after the second.
- rst asserted during HALF2 at k=3: next cycle all outputs are at reset values and FSM=IDLE. A new block then decodes normally from iter_cnt=1.
